// File: rtl/sync_ram_pkg.sv
// Shared constants and helpers for the sync_ram storage block.
//
// Contents:
//   ADDR_W   - default address bus width (bits)
//   DATA_W   - default data word width (bits)
//   DEPTH    - default number of stored words
//   in_range - returns 1 when an address selects a stored word (addr < DEPTH)
package sync_ram_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;

  // Extra top bit keeps the compare unsigned and free of truncation when
  // DEPTH == 2**ADDR_W.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
  endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered read port.
//
// Ports:
//   clk     in   1            rising-edge clock for all state
//   rst     in   1            synchronous reset, active-low; clears rd_data and every word
//   wr_data in   MEM_WIDTH    write data
//   addr    in   ADDER_WIDTH  shared read/write word address
//   wren    in   1            write enable, active-high
//   rden    in   1            read enable, active-high
//   rd_data out  MEM_WIDTH    registered read data (one-cycle latency, held while rden=0)
//
// Behaviour notes:
//   - Same-address read and write in one cycle is read-first: rd_data takes the
//     old word while the new word is stored.
//   - Addresses at or above MEM_DEPTH ignore writes and read back zero.
//   - Storage is a flop array so the whole memory can be cleared by reset.
module sync_ram
  import sync_ram_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDR_W,
  parameter int MEM_WIDTH   = DATA_W,
  parameter int MEM_DEPTH   = DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MEM_WIDTH-1:0]   wr_data,
  input  logic [ADDER_WIDTH-1:0] addr,
  input  logic                   wren,
  input  logic                   rden,
  output logic [MEM_WIDTH-1:0]   rd_data
);

  // Index width just wide enough for the stored words; never below one bit.
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDER_WIDTH:0] DEPTH_LIM = (ADDER_WIDTH + 1)'(MEM_DEPTH);

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic                 addr_ok;
  logic [IDX_W-1:0]     idx;
  logic [MEM_WIDTH-1:0] rd_word;

  // Range check done locally so non-default parameterisations stay correct.
  assign addr_ok = ({1'b0, addr} < DEPTH_LIM);

  // Only the low bits select a word; out-of-range addresses never reach the
  // array because both the write and the read path are gated by addr_ok.
  generate
    if (IDX_W < ADDER_WIDTH) begin : g_idx_slice
      assign idx = addr[IDX_W-1:0];
    end else begin : g_idx_pad
      assign idx = IDX_W'(addr);
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    if (addr_ok) begin
      rd_word = mem[idx];
    end
  end

  // Non-blocking updates give read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (rden) begin
        rd_data <= rd_word;
      end
      if (wren && addr_ok) begin
        mem[idx] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_sync_ram.sv
module tb_sync_ram;
  import sync_ram_pkg::*;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] addr;
  logic              wren;
  logic              rden;
  logic [DATA_W-1:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: an array of words and the last value handed out.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ref_rd;

  sync_ram #(
    .ADDER_WIDTH(ADDR_W),
    .MEM_WIDTH  (DATA_W),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_data(wr_data),
    .addr   (addr),
    .wren   (wren),
    .rden   (rden),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model advances on each rising edge from the inputs held stable since the
  // previous falling edge, then the DUT output is compared just after.
  always @(posedge clk) begin
    int a;
    logic [DATA_W-1:0] old_word;
    a = int'(addr);
    if (rst === 1'b0) begin
      ref_rd = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      old_word = (a < DEPTH) ? ref_mem[a] : '0;
      if (rden) ref_rd = old_word;
      if (wren && a < DEPTH) ref_mem[a] = wr_data;
    end
    #1;
    n_cmp++;
    if (rd_data !== ref_rd) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t addr=%0d got=%h exp=%h", $time, a, rd_data, ref_rd);
    end
  end

  task automatic cyc(input logic r, input logic we, input logic re,
                     input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    rst = r; wren = we; rden = re; addr = a; wr_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    rst = 1'b0; wren = 1'b0; rden = 1'b0; addr = '0; wr_data = '0;
    @(posedge clk); #2;
    chk("reset_rd", rd_data, 16'h0000);

    // Reset clears a previously written word and the whole array.
    cyc(1, 1, 0, 4'd2, 16'hFFFF);
    cyc(1, 0, 1, 4'd2, 16'h0000);
    chk("pre_reset_rd2", rd_data, 16'hFFFF);
    cyc(0, 0, 0, 4'd2, 16'h0000);
    chk("reset_pulse_rd", rd_data, 16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 1, ADDR_W'(i), 16'h0000);
      chk($sformatf("post_reset_rd%0d", i), rd_data, 16'h0000);
    end

    // Basic writes then reads, one-cycle latency.
    cyc(1, 1, 0, 4'd3, 16'h000B);
    cyc(1, 1, 0, 4'd7, 16'h0001);
    cyc(1, 1, 0, 4'd1, 16'h001C);
    cyc(1, 0, 1, 4'd3, 16'h0000); chk("rd3", rd_data, 16'h000B);
    cyc(1, 0, 1, 4'd1, 16'h0000); chk("rd1", rd_data, 16'h001C);
    cyc(1, 0, 1, 4'd7, 16'h0000); chk("rd7", rd_data, 16'h0001);
    cyc(1, 0, 1, 4'd1, 16'h0000); chk("rd1_again", rd_data, 16'h001C);

    // Hold with rden low, address moved.
    cyc(1, 0, 0, 4'd3, 16'h0000); chk("hold1", rd_data, 16'h001C);
    cyc(1, 0, 0, 4'd7, 16'h0000); chk("hold2", rd_data, 16'h001C);

    // Read-first collision.
    cyc(1, 1, 0, 4'd5, 16'h1234);
    cyc(1, 1, 1, 4'd5, 16'hABCD); chk("collide_old", rd_data, 16'h1234);
    cyc(1, 0, 1, 4'd5, 16'h0000); chk("collide_new", rd_data, 16'hABCD);

    // Out-of-range write ignored, read returns zero.
    cyc(1, 1, 0, 4'd9, 16'h5555);
    chk("model_alias_mem1", ref_mem[1], 16'h001C);
    cyc(1, 0, 1, 4'd1, 16'h0000); chk("alias_rd1", rd_data, 16'h001C);
    cyc(1, 0, 1, 4'd9, 16'h0000); chk("oor_rd9", rd_data, 16'h0000);
    cyc(1, 0, 1, 4'd15, 16'h0000); chk("oor_rd15", rd_data, 16'h0000);

    // Reset wins over a simultaneous write and read.
    cyc(1, 1, 0, 4'd4, 16'h4444);
    cyc(1, 0, 1, 4'd5, 16'h0000); chk("pre_prio_rd5", rd_data, 16'hABCD);
    cyc(0, 1, 1, 4'd4, 16'h7777); chk("prio_rd", rd_data, 16'h0000);
    cyc(1, 0, 1, 4'd4, 16'h0000); chk("prio_rd4", rd_data, 16'h0000);
    cyc(1, 0, 1, 4'd5, 16'h0000); chk("prio_rd5", rd_data, 16'h0000);

    // Randomised traffic; the compare process checks every edge.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 60) != 0),
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) != 0,
          ADDR_W'($urandom_range(0, 15)),
          DATA_W'($urandom));
    end

    // Full readback of every address against the model.
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 1, ADDR_W'(i), 16'h0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
